// File: rtl/uart_fifo_ext.sv
// Parametrised UART FIFO with optional first-word-fall-through read port, synchronous
// flush, high/low watermarks, sticky overflow/underflow flags and peak-level tracking.
module uart_fifo_ext #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  write_en,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  read_en,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   level,
  input  logic [ADDR_WIDTH:0]   hi_thresh,
  input  logic [ADDR_WIDTH:0]   lo_thresh,
  output logic                  hi_reached,
  output logic                  lo_reached,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH:0]   peak_level
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]  level_d, peak_d, peak_q;
  logic             overflow_q, underflow_q;
  logic             pop_ok, push_ok;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign empty      = (level == '0);
  assign full       = (level == PtrW'(DEPTH));
  assign hi_reached = (level >= hi_thresh);
  assign lo_reached = (level <= lo_thresh);
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign peak_level = peak_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push.
  assign pop_ok  = read_en && !empty;
  assign push_ok = write_en && (!full || pop_ok);

  always_comb begin
    level_d = '0;
    peak_d  = peak_q;
    if (!flush) begin
      level_d = level + PtrW'(push_ok) - PtrW'(pop_ok);
    end
    if (err_clr) begin
      peak_d = level_d;
    end else if (level_d > peak_q) begin
      peak_d = level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      peak_q      <= '0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      // New error events take precedence over a same-cycle clear.
      overflow_q  <= (write_en && !push_ok && !flush) || (overflow_q && !err_clr);
      underflow_q <= (read_en && empty) || (underflow_q && !err_clr);
      peak_q      <= peak_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out   = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign data_valid = !empty;
  end else begin : g_reg
    logic [WIDTH-1:0] data_out_q;
    logic             data_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_out_q   <= '0;
        data_valid_q <= 1'b0;
      end else if (flush) begin
        data_valid_q <= 1'b0;
      end else begin
        data_valid_q <= pop_ok;
        if (pop_ok) data_out_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
  end

endmodule
